sdram_arbit: RTL and testbench
==============================

Name: sdram_arbit

Overview:
Top-level scheduler for the SDRAM controller. It owns the SDRAM command/address/data pins and shares them between four command sources: init, auto-refresh, write and read. It holds the bus in the init source until init completes, then grants one of refresh, write or read at a time by fixed priority. It also steers that source's cmd/ba/addr onto the pins.

Parameters:
- IDLE_BA, 2'b11, bank value driven when no source is granted
- IDLE_ADDR, 13'h1fff, address value driven when no source is granted

Ports:
- sys_clk  in  1  system clock (SDRAM clock domain)
- sys_rst_n  in  1  asynchronous reset, active low
- init_cmd  in  4  init command {cs_n,ras_n,cas_n,we_n}
- init_ba  in  2  init bank
- init_addr  in  13  init address
- init_end  in  1  init complete; level, stays high after completion
- aref_req  in  1  refresh request; level, held until the grant is taken
- aref_end  in  1  one-cycle pulse, refresh sequence finished
- aref_cmd  in  4  refresh command
- aref_ba  in  2  refresh bank
- aref_addr  in  13  refresh address
- wr_req  in  1  write request; level
- wr_end  in  1  one-cycle pulse, write burst finished
- wr_cmd  in  4  write command
- wr_ba  in  2  write bank
- wr_addr  in  13  write address
- wr_sdram_en  in  1  write data-drive enable
- wr_sdram_data  in  16  write data
- rd_req  in  1  read request; level
- rd_end  in  1  one-cycle pulse, read burst finished
- rd_cmd  in  4  read command
- rd_ba  in  2  read bank
- rd_addr  in  13  read address
- aref_en  out  1  refresh grant
- wr_en  out  1  write grant
- rd_en  out  1  read grant
- sdram_cke  out  1  clock enable
- sdram_cs_n  out  1  chip select
- sdram_ras_n  out  1  row strobe
- sdram_cas_n  out  1  column strobe
- sdram_we_n  out  1  write enable
- sdram_ba  out  2  bank address
- sdram_addr  out  13  address
- sdram_dq  inout  16  data bus

Behaviour:
- Single clock domain (sys_clk). Asynchronous active-low reset (sys_rst_n) returns the state to INIT from any state, including mid-burst.
- State register, 3 bits, states:
  - INIT: after reset, stay until init_end=1, then go to ARBIT.
  - ARBIT: evaluate requests every cycle in this priority:
    - aref_req=1 → AREF
    - else wr_req=1 → WRITE
    - else rd_req=1 → READ
    - else stay in ARBIT
  - AREF: leave to ARBIT on the cycle aref_end=1.
  - WRITE: leave to ARBIT on the cycle wr_end=1.
  - READ: leave to ARBIT on the cycle rd_end=1.
  - Unused encodings → INIT.
- Requests are sampled only in ARBIT. Requests raised during a grant wait in the requester and are not queued here.
- Simultaneous aref_req and wr_req: refresh wins; write is granted after aref_end plus one ARBIT cycle.
- Each grant is a combinational decode of the registered state:
  - aref_en=(state==AREF), wr_en=(state==WRITE), rd_en=(state==READ).
  - Each enable rises one cycle after the ARBIT decision and falls the cycle after *_end. That cycle is ARBIT, so the sub-module (back in its idle state) sees the enable low and cannot restart.
  - At most one enable is high at any time.
- Minimum gap between two grants: one ARBIT cycle.
- *_end pulses from a source that is not granted are ignored.
- Pin mux is combinational from state:
  - INIT → init_*
  - AREF → aref_*
  - WRITE → wr_*
  - READ → rd_*
  - ARBIT/default → cmd 4'b0111 (NOP), ba IDLE_BA, addr IDLE_ADDR
- {sdram_cs_n,sdram_ras_n,sdram_cas_n,sdram_we_n} = selected cmd.
- sdram_cke is tied to 1. It is also 1 in reset.
- sdram_dq = wr_sdram_data when wr_sdram_en=1, else high-Z. The write module only raises wr_sdram_en while wr_en=1.
- Reset values:
  - state INIT; all enables 0.
  - Pins follow init_* (the init module drives NOP in reset); dq high-Z.
- If init_end drops after completion, the arbiter ignores it and stays operational.

Decomposition:
- Shared package sdram_pkg: command encodings NOP 4'b0111, P_CHARGE 4'b0010, A_REF 4'b0001, ACTIVE, WRITE, READ, B_STOP, M_REG_SET; arbiter state encodings; data width 16, addr width 13, ba width 2.
- No sub-module. The block is a single FSM plus a mux; the command mux may be a function in sdram_pkg.

Test Plan:
- Reset with init_end held 0 for 100 cycles → state INIT, pins follow init_cmd. Raise init_end → ARBIT next cycle, cmd 4'b0111, ba 2'b11, addr 13'h1fff.
- aref_req=1 in ARBIT → aref_en=1 next cycle, pins carry aref_cmd (e.g. 4'b0010). Pulse aref_end → aref_en=0 next cycle, NOP driven.
- aref_req and wr_req both raised in the same ARBIT cycle → aref_en granted first. wr_en rises 2 cycles after the aref_end pulse; wr_en and aref_en never both high.
- wr_req and rd_req both held → WRITE granted. After wr_end, READ granted once ARBIT sees wr_req=0. Check sdram_dq=16'h1234 only while wr_sdram_en=1, Z otherwise.
- Assert sys_rst_n=0 mid-READ → state INIT immediately (async), rd_en=0, dq Z. After release and init_end, normal arbitration resumes.
- Spurious rd_end pulse during WRITE → no state change; write completes only on wr_end.

Source files
------------

// File: rtl/sdram_pkg.sv
// ---------------------------------------------------------------------------
// sdram_pkg
// Shared definitions for the SDRAM controller slice:
//   - bus widths (data, address, bank)
//   - SDRAM command encodings {cs_n, ras_n, cas_n, we_n}
//   - arbiter state encodings
// ---------------------------------------------------------------------------
package sdram_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 13;
    localparam int BA_W   = 2;
    localparam int CMD_W  = 4;

    // SDRAM commands, bit order {cs_n, ras_n, cas_n, we_n}
    localparam logic [CMD_W-1:0] CMD_NOP       = 4'b0111;
    localparam logic [CMD_W-1:0] CMD_P_CHARGE  = 4'b0010;
    localparam logic [CMD_W-1:0] CMD_A_REF     = 4'b0001;
    localparam logic [CMD_W-1:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [CMD_W-1:0] CMD_WRITE     = 4'b0100;
    localparam logic [CMD_W-1:0] CMD_READ      = 4'b0101;
    localparam logic [CMD_W-1:0] CMD_B_STOP    = 4'b0110;
    localparam logic [CMD_W-1:0] CMD_M_REG_SET = 4'b0000;

    // Arbiter states. Encodings 5..7 are unused and recover to ST_INIT.
    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_ARBIT = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } arb_state_t;

    // One source's view of the command/address pins.
    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [BA_W-1:0]   ba;
        logic [ADDR_W-1:0] addr;
    } sdram_bus_t;

    // Pin mux: picks the granted source's bus, or the idle bus.
    function automatic sdram_bus_t bus_select(
        input arb_state_t state,
        input sdram_bus_t init_bus,
        input sdram_bus_t aref_bus,
        input sdram_bus_t wr_bus,
        input sdram_bus_t rd_bus,
        input sdram_bus_t idle_bus
    );
        sdram_bus_t sel;
        case (state)
            ST_INIT:  sel = init_bus;
            ST_AREF:  sel = aref_bus;
            ST_WRITE: sel = wr_bus;
            ST_READ:  sel = rd_bus;
            default:  sel = idle_bus;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/sdram_arbit.sv
// ---------------------------------------------------------------------------
// sdram_arbit
// Top-level scheduler of the SDRAM controller. Owns the SDRAM pins and
// shares them between the init, auto-refresh, write and read sources.
// The bus stays with init until init_end, then one of refresh / write /
// read is granted at a time by fixed priority (refresh > write > read).
//
// Ports:
//   sys_clk, sys_rst_n          clock, asynchronous active-low reset
//   init_*                      init source command/bank/address, init_end
//   aref_req/_end/_cmd/_ba/_addr  refresh source
//   wr_req/_end/_cmd/_ba/_addr    write source, plus wr_sdram_en/_data
//   rd_req/_end/_cmd/_ba/_addr    read source
//   aref_en, wr_en, rd_en       grants (decoded from the state register)
//   sdram_cke ... sdram_addr    SDRAM command/address pins
//   sdram_dq                    SDRAM data bus (driven only for writes)
// ---------------------------------------------------------------------------
module sdram_arbit
    import sdram_pkg::*;
#(
    parameter logic [BA_W-1:0]   IDLE_BA   = 2'b11,
    parameter logic [ADDR_W-1:0] IDLE_ADDR = 13'h1fff
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,

    input  logic [CMD_W-1:0]   init_cmd,
    input  logic [BA_W-1:0]    init_ba,
    input  logic [ADDR_W-1:0]  init_addr,
    input  logic               init_end,

    input  logic               aref_req,
    input  logic               aref_end,
    input  logic [CMD_W-1:0]   aref_cmd,
    input  logic [BA_W-1:0]    aref_ba,
    input  logic [ADDR_W-1:0]  aref_addr,

    input  logic               wr_req,
    input  logic               wr_end,
    input  logic [CMD_W-1:0]   wr_cmd,
    input  logic [BA_W-1:0]    wr_ba,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic               wr_sdram_en,
    input  logic [DATA_W-1:0]  wr_sdram_data,

    input  logic               rd_req,
    input  logic               rd_end,
    input  logic [CMD_W-1:0]   rd_cmd,
    input  logic [BA_W-1:0]    rd_ba,
    input  logic [ADDR_W-1:0]  rd_addr,

    output logic               aref_en,
    output logic               wr_en,
    output logic               rd_en,

    output logic               sdram_cke,
    output logic               sdram_cs_n,
    output logic               sdram_ras_n,
    output logic               sdram_cas_n,
    output logic               sdram_we_n,
    output logic [BA_W-1:0]    sdram_ba,
    output logic [ADDR_W-1:0]  sdram_addr,
    inout  wire  [DATA_W-1:0]  sdram_dq
);

    arb_state_t state_reg;
    arb_state_t state_next;
    sdram_bus_t pin_bus;

    // ---------------- state register ----------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg <= ST_INIT;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    // Requests are looked at only in ST_ARBIT; an *_end from a source that
    // does not hold the bus has no effect because only the granted state
    // tests its own *_end. init_end is ignored once we have left ST_INIT.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_INIT: begin
                if (init_end) state_next = ST_ARBIT;
            end
            ST_ARBIT: begin
                if (aref_req)      state_next = ST_AREF;
                else if (wr_req)   state_next = ST_WRITE;
                else if (rd_req)   state_next = ST_READ;
            end
            ST_AREF: begin
                if (aref_end) state_next = ST_ARBIT;
            end
            ST_WRITE: begin
                if (wr_end) state_next = ST_ARBIT;
            end
            ST_READ: begin
                if (rd_end) state_next = ST_ARBIT;
            end
            default: state_next = ST_INIT;
        endcase
    end

    // ---------------- outputs ----------------
    // Grants are pure decodes of the state register, so they are mutually
    // exclusive and always separated by at least one ST_ARBIT cycle.
    always_comb begin
        aref_en = (state_reg == ST_AREF);
        wr_en   = (state_reg == ST_WRITE);
        rd_en   = (state_reg == ST_READ);
        pin_bus = bus_select(state_reg,
                             '{cmd: init_cmd, ba: init_ba, addr: init_addr},
                             '{cmd: aref_cmd, ba: aref_ba, addr: aref_addr},
                             '{cmd: wr_cmd,   ba: wr_ba,   addr: wr_addr},
                             '{cmd: rd_cmd,   ba: rd_ba,   addr: rd_addr},
                             '{cmd: CMD_NOP,  ba: IDLE_BA, addr: IDLE_ADDR});
    end

    assign sdram_cke = 1'b1;
    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = pin_bus.cmd;
    assign sdram_ba   = pin_bus.ba;
    assign sdram_addr = pin_bus.addr;

    // The write source only raises wr_sdram_en while it holds wr_en.
    assign sdram_dq = wr_sdram_en ? wr_sdram_data : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sdram_arbit.sv
// ---------------------------------------------------------------------------
// tb_sdram_arbit
// Directed, table-driven bench for sdram_arbit plus hand-written sequences
// for reset and asynchronous reset in the middle of a read.
// ---------------------------------------------------------------------------
module tb_sdram_arbit;

    // Which bus is expected on the pins
    localparam int SEL_INIT = 0;
    localparam int SEL_IDLE = 1;
    localparam int SEL_AREF = 2;
    localparam int SEL_WR   = 3;
    localparam int SEL_RD   = 4;

    // Fixed, mutually distinct source buses
    localparam logic [3:0]  INIT_CMD  = 4'b0010;
    localparam logic [1:0]  INIT_BA   = 2'b00;
    localparam logic [12:0] INIT_ADDR = 13'h0400;
    localparam logic [3:0]  AREF_CMD  = 4'b0001;
    localparam logic [1:0]  AREF_BA   = 2'b01;
    localparam logic [12:0] AREF_ADDR = 13'h0111;
    localparam logic [3:0]  WR_CMD    = 4'b0100;
    localparam logic [1:0]  WR_BA     = 2'b10;
    localparam logic [12:0] WR_ADDR   = 13'h0222;
    localparam logic [3:0]  RD_CMD    = 4'b0101;
    localparam logic [1:0]  RD_BA     = 2'b01;
    localparam logic [12:0] RD_ADDR   = 13'h0333;
    localparam logic [15:0] WR_DATA   = 16'h1234;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [3:0]  init_cmd;
    logic [1:0]  init_ba;
    logic [12:0] init_addr;
    logic        init_end;
    logic        aref_req, aref_end;
    logic [3:0]  aref_cmd;
    logic [1:0]  aref_ba;
    logic [12:0] aref_addr;
    logic        wr_req, wr_end;
    logic [3:0]  wr_cmd;
    logic [1:0]  wr_ba;
    logic [12:0] wr_addr;
    logic        wr_sdram_en;
    logic [15:0] wr_sdram_data;
    logic        rd_req, rd_end;
    logic [3:0]  rd_cmd;
    logic [1:0]  rd_ba;
    logic [12:0] rd_addr;
    logic        aref_en, wr_en, rd_en;
    logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_addr;
    wire  [15:0] sdram_dq;

    int errors = 0;
    int checks = 0;

    always #5 sys_clk = ~sys_clk;

    sdram_arbit dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .init_cmd      (init_cmd),
        .init_ba       (init_ba),
        .init_addr     (init_addr),
        .init_end      (init_end),
        .aref_req      (aref_req),
        .aref_end      (aref_end),
        .aref_cmd      (aref_cmd),
        .aref_ba       (aref_ba),
        .aref_addr     (aref_addr),
        .wr_req        (wr_req),
        .wr_end        (wr_end),
        .wr_cmd        (wr_cmd),
        .wr_ba         (wr_ba),
        .wr_addr       (wr_addr),
        .wr_sdram_en   (wr_sdram_en),
        .wr_sdram_data (wr_sdram_data),
        .rd_req        (rd_req),
        .rd_end        (rd_end),
        .rd_cmd        (rd_cmd),
        .rd_ba         (rd_ba),
        .rd_addr       (rd_addr),
        .aref_en       (aref_en),
        .wr_en         (wr_en),
        .rd_en         (rd_en),
        .sdram_cke     (sdram_cke),
        .sdram_cs_n    (sdram_cs_n),
        .sdram_ras_n   (sdram_ras_n),
        .sdram_cas_n   (sdram_cas_n),
        .sdram_we_n    (sdram_we_n),
        .sdram_ba      (sdram_ba),
        .sdram_addr    (sdram_addr),
        .sdram_dq      (sdram_dq)
    );

    typedef struct {
        string name;
        bit    init_end;
        bit    aref_req;
        bit    aref_end;
        bit    wr_req;
        bit    wr_end;
        bit    rd_req;
        bit    rd_end;
        bit    dq_en;
        bit [2:0] exp_en;   // {aref_en, wr_en, rd_en} after the edge
        int    exp_sel;     // bus expected on the pins after the edge
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, bit ie, bit arq, bit aen, bit wrq,
                                bit wen, bit rrq, bit ren, bit dq,
                                bit [2:0] en, int sel);
        vec_t v;
        v.name = name; v.init_end = ie;
        v.aref_req = arq; v.aref_end = aen;
        v.wr_req = wrq; v.wr_end = wen;
        v.rd_req = rrq; v.rd_end = ren;
        v.dq_en = dq; v.exp_en = en; v.exp_sel = sel;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare every observable output against the expected grant set,
    // selected pin bus and data-bus drive.
    task automatic check_outputs(string tag, bit [2:0] en, int sel, bit dq_on);
        logic [3:0]  e_cmd;
        logic [1:0]  e_ba;
        logic [12:0] e_addr;
        case (sel)
            SEL_INIT: begin e_cmd = INIT_CMD; e_ba = INIT_BA; e_addr = INIT_ADDR; end
            SEL_AREF: begin e_cmd = AREF_CMD; e_ba = AREF_BA; e_addr = AREF_ADDR; end
            SEL_WR:   begin e_cmd = WR_CMD;   e_ba = WR_BA;   e_addr = WR_ADDR;   end
            SEL_RD:   begin e_cmd = RD_CMD;   e_ba = RD_BA;   e_addr = RD_ADDR;   end
            default:  begin e_cmd = 4'b0111;  e_ba = 2'b11;   e_addr = 13'h1fff;  end
        endcase
        chk({tag, ".en"},   {29'd0, aref_en, wr_en, rd_en}, {29'd0, en});
        chk({tag, ".cmd"},  {28'd0, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n},
                            {28'd0, e_cmd});
        chk({tag, ".ba"},   {30'd0, sdram_ba},   {30'd0, e_ba});
        chk({tag, ".addr"}, {19'd0, sdram_addr}, {19'd0, e_addr});
        chk({tag, ".cke"},  {31'd0, sdram_cke},  32'd1);
        checks++;
        if (dq_on) begin
            if (sdram_dq !== WR_DATA) begin
                errors++;
                $display("FAIL %s.dq: got %0h expected %0h", tag, sdram_dq, WR_DATA);
            end
        end else begin
            // Released bus: 4-state simulators show Z, 2-state ones show 0.
            if (!((sdram_dq === 16'hzzzz) || (sdram_dq === 16'h0000))) begin
                errors++;
                $display("FAIL %s.dq: got %0h expected released (z)", tag, sdram_dq);
            end
        end
        $display("%-22s en=%b%b%b cmd=%b ba=%0d addr=%h dq=%h", tag,
                 aref_en, wr_en, rd_en,
                 {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n},
                 sdram_ba, sdram_addr, sdram_dq);
    endtask

    task automatic clear_ctrl();
        init_end = 1'b0; aref_req = 1'b0; aref_end = 1'b0;
        wr_req = 1'b0; wr_end = 1'b0; rd_req = 1'b0; rd_end = 1'b0;
        wr_sdram_en = 1'b0;
    endtask

    initial begin
        init_cmd = INIT_CMD; init_ba = INIT_BA; init_addr = INIT_ADDR;
        aref_cmd = AREF_CMD; aref_ba = AREF_BA; aref_addr = AREF_ADDR;
        wr_cmd   = WR_CMD;   wr_ba   = WR_BA;   wr_addr   = WR_ADDR;
        rd_cmd   = RD_CMD;   rd_ba   = RD_BA;   rd_addr   = RD_ADDR;
        wr_sdram_data = WR_DATA;
        clear_ctrl();

        //          name               ie ar ae wr we rr re dq  en      sel
        vecs.push_back(mk("init_done",     1,0,0,0,0,0,0,0, 3'b000, SEL_IDLE));
        vecs.push_back(mk("arbit_idle",    1,0,0,0,0,0,0,0, 3'b000, SEL_IDLE));
        vecs.push_back(mk("aref_grant",    1,1,0,0,0,0,0,0, 3'b100, SEL_AREF));
        vecs.push_back(mk("aref_hold",     1,0,0,0,0,0,0,0, 3'b100, SEL_AREF));
        vecs.push_back(mk("aref_spur_wend",1,0,0,0,1,0,0,0, 3'b100, SEL_AREF));
        vecs.push_back(mk("aref_end",      1,0,1,0,0,0,0,0, 3'b000, SEL_IDLE));
        vecs.push_back(mk("aref_wr_both",  1,1,0,1,0,0,0,0, 3'b100, SEL_AREF));
        vecs.push_back(mk("wr_wait",       1,0,0,1,0,0,0,0, 3'b100, SEL_AREF));
        vecs.push_back(mk("aref_end2",     1,0,1,1,0,0,0,0, 3'b000, SEL_IDLE));
        vecs.push_back(mk("wr_grant",      1,0,0,1,0,0,0,0, 3'b010, SEL_WR));
        vecs.push_back(mk("wr_spur_rend",  1,0,0,0,0,1,1,0, 3'b010, SEL_WR));
        vecs.push_back(mk("wr_data_on",    1,0,0,0,0,1,0,1, 3'b010, SEL_WR));
        vecs.push_back(mk("wr_end",        1,0,0,0,1,1,0,0, 3'b000, SEL_IDLE));
        vecs.push_back(mk("rd_grant",      1,0,0,0,0,1,0,0, 3'b001, SEL_RD));
        vecs.push_back(mk("rd_end",        1,0,0,0,0,0,1,0, 3'b000, SEL_IDLE));
        vecs.push_back(mk("init_drop",     0,0,0,0,0,0,0,0, 3'b000, SEL_IDLE));
        vecs.push_back(mk("wr_no_init",    0,0,0,1,0,0,0,0, 3'b010, SEL_WR));
        vecs.push_back(mk("wr_end2",       1,0,0,0,1,0,0,0, 3'b000, SEL_IDLE));
        vecs.push_back(mk("wr_rd_both",    1,0,0,1,0,1,0,0, 3'b010, SEL_WR));
        vecs.push_back(mk("wr_end_rd_wait",1,0,0,0,1,1,0,0, 3'b000, SEL_IDLE));
        vecs.push_back(mk("rd_grant2",     1,0,0,0,0,1,0,0, 3'b001, SEL_RD));
        vecs.push_back(mk("rd_busy",       1,0,0,0,0,0,0,0, 3'b001, SEL_RD));

        // ---- reset: asynchronous, pins follow init, dq released ----
        sys_rst_n = 1'b0;
        #3;
        check_outputs("in_reset", 3'b000, SEL_INIT, 1'b0);
        repeat (3) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        repeat (100) @(posedge sys_clk);
        #1;
        check_outputs("init_wait_100", 3'b000, SEL_INIT, 1'b0);

        // ---- table: apply inputs, take one edge, check the new state ----
        foreach (vecs[i]) begin
            init_end    = vecs[i].init_end;
            aref_req    = vecs[i].aref_req;
            aref_end    = vecs[i].aref_end;
            wr_req      = vecs[i].wr_req;
            wr_end      = vecs[i].wr_end;
            rd_req      = vecs[i].rd_req;
            rd_end      = vecs[i].rd_end;
            wr_sdram_en = vecs[i].dq_en;
            @(posedge sys_clk);
            #1;
            check_outputs(vecs[i].name, vecs[i].exp_en, vecs[i].exp_sel, vecs[i].dq_en);
        end

        // ---- asynchronous reset in the middle of a read ----
        clear_ctrl();
        init_end = 1'b1;
        #2 sys_rst_n = 1'b0;
        #1;
        check_outputs("rst_mid_read", 3'b000, SEL_INIT, 1'b0);
        @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        init_end = 1'b0;
        @(posedge sys_clk);
        #1;
        check_outputs("post_rst_init", 3'b000, SEL_INIT, 1'b0);
        init_end = 1'b1;
        @(posedge sys_clk);
        #1;
        check_outputs("post_rst_arbit", 3'b000, SEL_IDLE, 1'b0);
        rd_req = 1'b1;
        @(posedge sys_clk);
        #1;
        check_outputs("post_rst_rd", 3'b001, SEL_RD, 1'b0);
        rd_req = 1'b0; rd_end = 1'b1;
        @(posedge sys_clk);
        #1;
        rd_end = 1'b0;
        check_outputs("post_rst_rd_end", 3'b000, SEL_IDLE, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Grants must never overlap; checked on every falling edge.
    always @(negedge sys_clk) begin
        if ((32'(aref_en) + 32'(wr_en) + 32'(rd_en)) > 1) begin
            checks++;
            errors++;
            $display("FAIL onehot: got %b%b%b expected at most one", aref_en, wr_en, rd_en);
        end
    end

endmodule
